// File: rtl/regfile_write_buffer.sv
// Write staging buffer in front of the RegFile write port: merges two producers into
// an in-order FIFO, drains one entry per cycle, and forwards pending data to readers.
module regfile_write_buffer #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int cnt_width  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENQ0_EN,
    input  logic [addr_width-1:0] ENQ0_ADDR,
    input  logic [data_width-1:0] ENQ0_DATA,
    output logic                  ENQ0_RDY,
    input  logic                  ENQ1_EN,
    input  logic [addr_width-1:0] ENQ1_ADDR,
    input  logic [data_width-1:0] ENQ1_DATA,
    output logic                  ENQ1_RDY,
    input  logic                  HOLD,
    output logic                  WE,
    output logic [addr_width-1:0] ADDR_IN,
    output logic [data_width-1:0] D_IN,
    input  logic [addr_width-1:0] LKP_ADDR,
    output logic                  LKP_HIT,
    output logic [data_width-1:0] LKP_DATA,
    output logic [cnt_width-1:0]  COUNT
);

    localparam int PW = $clog2(depth);
    localparam logic [cnt_width-1:0] DEPTH_C = cnt_width'(depth);

    logic [addr_width-1:0] r_addr [depth];
    logic [data_width-1:0] r_data [depth];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [cnt_width-1:0]  r_count;
    logic                  r_rr;
    logic                  r_we;
    logic [addr_width-1:0] r_outAddr;
    logic [data_width-1:0] r_outData;

    logic [cnt_width-1:0]  w_free;
    logic                  w_enq0;
    logic                  w_enq1;
    logic                  w_deq;
    logic                  w_lastSlot;
    logic [PW-1:0]         w_slot1;
    logic [PW-1:0]         w_idx;
    logic                  w_hit;
    logic [data_width-1:0] w_lkpData;

    // Readiness uses only registered occupancy, so a full buffer never accepts
    // even when it drains in the same cycle; rr arbitrates the very last slot.
    assign w_free     = DEPTH_C - r_count;
    assign w_lastSlot = (w_free == cnt_width'(1));
    assign ENQ0_RDY   = (w_free >= cnt_width'(2)) | (w_lastSlot & ~r_rr);
    assign ENQ1_RDY   = (w_free >= cnt_width'(2)) | (w_lastSlot &  r_rr);
    assign w_enq0     = ENQ0_EN & ENQ0_RDY;
    assign w_enq1     = ENQ1_EN & ENQ1_RDY;
    assign w_deq      = (r_count != '0) & ~HOLD;
    assign w_slot1    = r_tail + PW'(w_enq0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < depth; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_enq0) begin
                r_addr[r_tail] <= ENQ0_ADDR;
                r_data[r_tail] <= ENQ0_DATA;
            end
            if (w_enq1) begin
                r_addr[w_slot1] <= ENQ1_ADDR;
                r_data[w_slot1] <= ENQ1_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rr      <= 1'b0;
            r_we      <= 1'b0;
            r_outAddr <= '0;
            r_outData <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_enq0) + PW'(w_enq1);
            r_count <= r_count + cnt_width'(w_enq0) + cnt_width'(w_enq1) - cnt_width'(w_deq);
            if (w_lastSlot & (w_enq0 | w_enq1)) begin
                r_rr <= ~r_rr;
            end
            r_we <= w_deq;
            if (w_deq) begin
                r_outAddr <= r_addr[r_head];
                r_outData <= r_data[r_head];
                r_head    <= r_head + PW'(1);
            end
        end
    end

    // Oldest first (output stage, then head towards tail) so the youngest match overrides.
    always_comb begin
        w_idx     = '0;
        w_hit     = r_we & (r_outAddr == LKP_ADDR);
        w_lkpData = w_hit ? r_outData : '0;
        for (int i = 0; i < depth; i++) begin
            w_idx = r_head + PW'(i);
            if ((cnt_width'(i) < r_count) && (r_addr[w_idx] == LKP_ADDR)) begin
                w_hit     = 1'b1;
                w_lkpData = r_data[w_idx];
            end
        end
    end

    assign LKP_HIT  = w_hit;
    assign LKP_DATA = w_lkpData;
    assign WE       = r_we;
    assign ADDR_IN  = r_outAddr;
    assign D_IN     = r_outData;
    assign COUNT    = r_count;

endmodule
